// File: rtl/fir_out_if.sv
// fir_out_if: groups the FIR output-stage signals.
// master = datapath/consumer side (drives y, strobes, stall, clear).
// slave  = the fir_out block itself.
interface fir_out_if #(
  parameter int DEPTH = 4
);
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic               y_valid;
  logic [17:0]        y;
  logic               sout_hold;
  logic               clear_ovf;
  logic               sout;
  logic               sout_frame;
  logic               sat;
  logic               overflow;
  logic [7:0]         drop_cnt;
  logic [LEVEL_W-1:0] level;

  modport master (
    output y_valid, y, sout_hold, clear_ovf,
    input  sout, sout_frame, sat, overflow, drop_cnt, level
  );

  modport slave (
    input  y_valid, y, sout_hold, clear_ovf,
    output sout, sout_frame, sat, overflow, drop_cnt, level
  );
endinterface

// File: rtl/fir_out.sv
// fir_out: output stage of the 4-tap FIR. Scales each result by a right
// shift, saturates to 8 unsigned bits, buffers it in a DEPTH-entry FIFO and
// sends it MSB-first on a framed serial line. Reports clipping and drops.
// Optional feature macro: FIR_OUT_ROUND_EN (round half-up instead of truncate).
module fir_out #(
  parameter int DEPTH = 4,
  parameter int SHIFT = 8
) (
  input  logic     clk,
  input  logic     reset,
  fir_out_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef FIR_OUT_ROUND_EN
  localparam logic [18:0] ROUND_ADD = 19'(1) << (SHIFT - 1);
`else
  localparam logic [18:0] ROUND_ADD = '0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} tx_state_e;

  tx_state_e         state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              sat_q, sat_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [18:0]       sum;
  logic [18:0]       q;
  logic              clip;
  logic [7:0]        word;
  logic              full, empty, pop, push, drop;

  // Scale and saturate the incoming result (19-bit sum cannot wrap).
  always_comb begin
    sum  = {1'b0, bus.y} + ROUND_ADD;
    q    = sum >> SHIFT;
    clip = |q[18:8];
    word = clip ? 8'hFF : q[7:0];
  end

  // FIFO push/pop/drop decisions; a pop frees a slot for a same-edge write.
  always_comb begin
    full  = (count_q == LW'(DEPTH));
    empty = (count_q == '0);
    pop   = (state_q == ST_IDLE) && !empty && !bus.sout_hold;
    push  = bus.y_valid && (!full || pop);
    drop  = bus.y_valid && full && !pop;
  end

  // Next-state for pointers, occupancy and status flags.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    sat_d      = bus.y_valid && clip;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clear_ovf)
        drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (bus.clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Transmitter FSM: load on pop, shift 8 unstalled cycles, one gap cycle.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          sh_d      = mem_q[rd_ptr_q];
          bit_cnt_d = 3'd0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!bus.sout_hold) begin
          sh_d = {sh_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage write port.
  // NOTE: storage is deliberately not reset; resetting the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  // Control and status registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      sat_q      <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      sat_q      <= sat_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.sout       = (state_q == ST_SHIFT) && sh_q[7];
  assign bus.sout_frame = (state_q == ST_SHIFT);
  assign bus.sat        = sat_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.level      = count_q;
endmodule

// File: tb/tb_fir_out.sv
// tb_fir_out: scoreboard bench for fir_out (DEPTH=4, SHIFT=8). A reference
// model queues each accepted word at stimulus time; a monitor deserialises
// the serial line and compares whole words plus per-cycle status outputs.
module tb_fir_out;
  localparam int DEPTH = 4;
  localparam int SHIFT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  fir_out_if #(.DEPTH(DEPTH)) bus ();
  fir_out #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Unsaturated scaled value straight from the arithmetic rule.
  function automatic int raw_q(input int yv);
`ifdef FIR_OUT_ROUND_EN
    return (yv + (1 << (SHIFT - 1))) >> SHIFT;
`else
    return yv >> SHIFT;
`endif
  endfunction

  // ---------------- reference model ----------------
  int             m_level = 0;
  bit             m_ovf = 0;
  int             m_drop = 0;
  bit             m_sat = 0;
  int             m_bits = 0;   // frame bits still to send
  bit             m_gap = 0;    // gap cycle pending
  byte unsigned   exp_q[$];

  always @(posedge clk or posedge reset) begin : model
    bit pop, acc, drp;
    int qv;
    if (reset) begin
      m_level = 0; m_ovf = 0; m_drop = 0; m_sat = 0; m_bits = 0; m_gap = 0;
      exp_q.delete();
    end else begin
      pop = (m_bits == 0) && !m_gap && (m_level > 0) && !bus.sout_hold;
      acc = bus.y_valid && ((m_level < DEPTH) || pop);
      drp = bus.y_valid && !acc;
      qv  = raw_q(int'(bus.y));
      m_sat = bus.y_valid && (qv > 255);
      if (acc) exp_q.push_back(byte'(qv > 255 ? 255 : qv));
      m_level = m_level + int'(acc) - int'(pop);
      if (drp) begin
        m_ovf  = 1;
        m_drop = bus.clear_ovf ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
      end else if (bus.clear_ovf) begin
        m_ovf = 0; m_drop = 0;
      end
      if (pop) m_bits = 8;
      else if (m_bits > 0 && !bus.sout_hold) begin
        m_bits--;
        if (m_bits == 0) m_gap = 1;
      end else if (m_gap) m_gap = 0;
    end
  end

  // ---------------- monitor ----------------
  int         frame_run = 0, last_run = 0, frame_start = 0, nbits = 0, words_seen = 0, frames_seen = 0;
  logic [7:0] acc_w = '0, last_word = '0;

  always @(negedge clk) begin
    if (reset) begin
      nbits = 0; frame_run = 0;
    end else begin
      check("level", 32'(bus.level), 32'(m_level));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
      check("sat", 32'(bus.sat), 32'(m_sat));
      if (bus.sout_frame) begin
        if (frame_run == 0) begin frame_start = cyc; frames_seen++; end
        frame_run++;
        if (!bus.sout_hold) begin
          acc_w = {acc_w[6:0], bus.sout};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            words_seen++;
            last_word = acc_w;
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("word", 32'(acc_w), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        check("sout_idle", 32'(bus.sout), 32'd0);
        if (frame_run != 0) begin
          last_run  = frame_run;
          frame_run = 0;
          check("frame_whole", 32'(nbits), 32'd0);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [17:0] yv);
    bus.y = yv; bus.y_valid = 1'b1;
    tick();
    bus.y_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int t0, ws0, fs0;
    bus.y_valid = 1'b0; bus.y = '0; bus.sout_hold = 1'b0; bus.clear_ovf = 1'b0;
    #3;
    check("rst_sout", 32'(bus.sout), 32'd0);
    check("rst_frame", 32'(bus.sout_frame), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Basic word: first bit in T+2, eight frame cycles.
    t0 = cyc;
    strobe(18'h00180);
    tick(14);
    check("basic_start", 32'(frame_start), 32'(t0 + 2));
    check("basic_len", 32'(last_run), 32'd8);
`ifdef FIR_OUT_ROUND_EN
    check("basic_word", 32'(last_word), 32'h02);
`else
    check("basic_word", 32'(last_word), 32'h01);
`endif

    // Saturation: full-scale clips; 0xFF80 lands on 0xFF.
    strobe(18'h3FFFF);
    check("sat_pulse", 32'(bus.sat), 32'd1);
    tick();
    check("sat_once", 32'(bus.sat), 32'd0);
    tick(13);
    check("sat_word", 32'(last_word), 32'hFF);
    strobe(18'h0FF80);
    tick(14);
    check("ff80_word", 32'(last_word), 32'hFF);

    // Overflow: five strobes while stalled.
    bus.sout_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(18'(32'h1000 * (i + 3)));
      tick();
    end
    check("ovf_level", 32'(bus.level), 32'd4);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_cnt", 32'(bus.drop_cnt), 32'd1);

    // Clear coinciding with a drop: the drop wins.
    bus.clear_ovf = 1'b1;
    strobe(18'h01234);
    bus.clear_ovf = 1'b0;
    check("clrdrop_flag", 32'(bus.overflow), 32'd1);
    check("clrdrop_cnt", 32'(bus.drop_cnt), 32'd1);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    check("clr_flag", 32'(bus.overflow), 32'd0);
    check("clr_cnt", 32'(bus.drop_cnt), 32'd0);

    // Drop counter saturates at 255.
    bus.y_valid = 1'b1; bus.y = 18'h00500;
    tick(260);
    bus.y_valid = 1'b0;
    check("drop_sat", 32'(bus.drop_cnt), 32'd255);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;

    // Release: the four queued words come out in order.
    ws0 = words_seen;
    bus.sout_hold = 1'b0;
    tick(60);
    check("ovf_words", 32'(words_seen), 32'(ws0 + 4));

    // Stall after the 3rd bit for five cycles.
    strobe(18'h05A00);   // cycle T; now in T+1
    tick(4);             // now in T+5, 4th bit on sout
    bus.sout_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_bit", 32'(bus.sout), 32'd1);
      check("stall_frame", 32'(bus.sout_frame), 32'd1);
      tick();
    end
    bus.sout_hold = 1'b0;
    tick(12);
    check("stall_len", 32'(last_run), 32'd13);
    check("stall_word", 32'(last_word), 32'h5A);

    // Reset during bit 5 with two words queued.
    bus.sout_hold = 1'b1;
    strobe(18'h0AA00); strobe(18'h05500); strobe(18'h0F000);
    bus.sout_hold = 1'b0;
    tick(5);
    #2 reset = 1'b1;
    #1;
    check("rstmid_sout", 32'(bus.sout), 32'd0);
    check("rstmid_frame", 32'(bus.sout_frame), 32'd0);
    check("rstmid_level", 32'(bus.level), 32'd0);
    tick();
    reset = 1'b0;
    fs0 = frames_seen;
    tick(40);
    check("rstmid_noframe", 32'(frames_seen), 32'(fs0));

    // Randomised traffic with bursty stalls and occasional clears.
    for (int i = 0; i < 3000; i++) begin
      bus.y_valid   = ($urandom_range(0, 3) == 0);
      bus.y         = ($urandom_range(0, 3) == 0) ? 18'(18'h3FFFF - $urandom_range(0, 600))
                                                  : 18'($urandom);
      if ($urandom_range(0, 15) == 0) bus.sout_hold = ~bus.sout_hold;
      bus.clear_ovf = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.y_valid = 1'b0; bus.sout_hold = 1'b0; bus.clear_ovf = 1'b0;
    tick(80);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_out.md
# fir_out

Output stage of the 4-tap FIR filter, directly downstream of the MAC datapath. Captures each 18-bit filter result `y` when the datapath updates it, scales it by a fixed right shift, saturates it to 8 unsigned bits, and buffers it in a small FIFO. A serial transmitter sends each word MSB-first with a frame strobe. The block also reports saturation and dropped samples.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `SHIFT`, 8: right shift applied to `y`; 1..10.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `y_valid`  in  1  one-cycle strobe: `y` holds a new result this cycle. Driven from the datapath `enData` delayed one cycle.
- `y`  in  18  unsigned filter result from the datapath output register.
- `sout_hold`  in  1  stall request from the serial consumer.
- `clear_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`.
- `sout`  out  1  serial data, MSB first.
- `sout_frame`  out  1  high while the 8 bits of a word are valid on `sout`.
- `sat`  out  1  one-cycle pulse: the last captured word was clipped.
- `overflow`  out  1  sticky flag: at least one word was dropped.
- `drop_cnt`  out  8  count of dropped words; saturates at 255.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Scaling:** `q = y >> SHIFT`. The sum is formed 19 bits wide, so it never wraps.
  - When `q > 255`, the stored value is 0xFF and `sat` pulses.
  - Otherwise the stored value is `q[7:0]`.
- **Write:** when `y_valid` is high, the scaled word is written at the end of that cycle.
  - If the FIFO is full and no pop happens on the same edge, the word is dropped: `overflow` sets and `drop_cnt` increments.
  - Full with a simultaneous pop: the write is accepted and `level` is unchanged.
- **Read pointer** wraps modulo DEPTH, as does the write pointer.
- **Transmitter FSM:** states IDLE, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty and `sout_hold` is low, pop one word into the 8-bit shift register and go to SHIFT.
  - SHIFT: `sout_frame` is 1 and `sout` is the shift register MSB.
    - Each cycle with `sout_hold` low, shift left and increment the bit counter.
    - After bit 0 has been presented (8 unstalled cycles), go to GAP.
    - A cycle with `sout_hold` high freezes `sout`, the counter and `sout_frame`.
  - GAP: one cycle with `sout_frame` low and `sout` 0, then go to IDLE. Between words `sout_frame` is therefore low for at least 2 cycles (GAP plus IDLE load).
- **`clear_ovf`:** clears `overflow` and `drop_cnt`. If a drop happens in the same cycle, the drop wins: `overflow` is 1 and `drop_cnt` is 1.

## Timing
- Reset (asynchronous, takes effect immediately): `sout`=0, `sout_frame`=0, `sat`=0, `overflow`=0, `drop_cnt`=0, `level`=0, FSM in IDLE, pointers 0.
- Reset during a frame aborts the word; the FIFO contents are discarded.
- With an empty FIFO, `y_valid` in cycle T gives:
  - `level` = 1 in T+1;
  - pop at the end of T+1;
  - the first bit on `sout` with `sout_frame` high in T+2;
  - the last bit in T+9; GAP in T+10.
- `sat` is registered and pulses in T+1 for a `y_valid` in T.
- Sustained throughput: one word per 10 cycles. The datapath produces at most one result per 5 cycles, so bursts rely on the FIFO.

## Configuration
- `FIR_OUT_ROUND_EN`
  - Defined: round half-up, `q = (y + 2^(SHIFT-1)) >> SHIFT`.
  - Undefined: truncate, `q = y >> SHIFT`.
  - Saturation behaviour is the same in both cases.

## Test plan
All scenarios use SHIFT=8 and DEPTH=4.
- **Basic word:** reset; `y`=0x00180 with `y_valid` in cycle T.
  - `FIR_OUT_ROUND_EN` defined: `sout` = 0,0,0,0,0,0,1,0 over T+2..T+9, `sout_frame` high exactly those 8 cycles.
  - `FIR_OUT_ROUND_EN` undefined: bits 00000001.
- **Saturation:** `y`=0x3FFFF, `y_valid` in T.
  - `sat`=1 in T+1 only; the serial word is 0xFF.
  - `y`=0x0FF80 (without rounding) gives 0xFF with `sat`=0.
- **Overflow:** hold `sout_hold`=1 and strobe `y_valid` 5 times.
  - `level` = 4, `overflow`=1, `drop_cnt`=1.
  - Releasing `sout_hold` emits the first 4 words in order.
- **Stall mid-frame:** assert `sout_hold` for 5 cycles after the 3rd bit.
  - `sout_frame` stays high for 13 cycles.
  - `sout` holds the 4th bit throughout the stall.
  - The word arrives intact.
- **Clear vs drop:** `clear_ovf` in the same cycle as a drop (FIFO full, no pop).
  - `overflow`=1 and `drop_cnt`=1 afterwards.
  - `clear_ovf` alone then gives 0 and 0.
- **Reset mid-operation:** assert `reset` during bit 5 with 2 words queued.
  - `sout`, `sout_frame` and `level` go to 0 immediately.
  - No frame appears after reset is released.
